dm_dmi_responder: RTL and testbench
===================================

# dm_dmi_responder

Debug-module-side responder for DMI transactions. It sits in the core clock domain, downstream of the DMI clock-domain crossing. It accepts {addr, data, op} requests, decodes the DM register file and drives hart control (halt/resume/ndmreset). It runs abstract register-access commands against the core and returns one {addr, data, op} response per accepted request.

## Interface
Parameters:
- DMI_ADDR_BITS, 7, DMI address width
- DMI_DATA_BITS, 32, DMI data width
- DMI_OP_BITS, 2, op/status width
- DMI_REQ_BITS, DMI_ADDR_BITS+DMI_DATA_BITS+DMI_OP_BITS, request/response word width; layout {addr, data, op}

Ports (one clock; reset is synchronous and active-low):
- clk_i  in  1  core clock
- rst_ni  in  1  synchronous active-low reset
- dmi_data_i  in  DMI_REQ_BITS  request word
- dmi_valid_i  in  1  request valid
- dm_ready_o  out  1  request accepted when valid & ready
- dm_data_o  out  DMI_REQ_BITS  response word
- dm_valid_o  out  1  response valid
- dmi_ready_i  in  1  response consumed when valid & ready
- halt_req_o  out  1  level halt request to hart
- resume_req_o  out  1  resume request, held until hart runs
- ndmreset_o  out  1  non-debug-module reset
- halted_i  in  1  hart halted status
- cmd_req_o  out  1  abstract register access request
- cmd_we_o  out  1  1 = write GPR/CSR
- cmd_addr_o  out  16  regno
- cmd_wdata_o  out  32  write data (data0)
- cmd_ack_i  in  1  access complete (single-cycle pulse)
- cmd_rdata_i  in  32  read data, valid with cmd_ack_i

## Operation
- Request op: 0 nop, 1 read, 2 write, 3 reserved (treated as nop). Response op: 0 success, 3 busy. Response addr echoes the request addr. Response data is read data for reads and 0 otherwise.
- DMI FSM states are S_IDLE, S_EXEC and S_RESP, one-hot.
  - S_IDLE: dm_ready_o=1. A handshake latches the request and moves to S_EXEC.
  - S_EXEC: performs the register read/write and latches the response, then moves to S_RESP.
  - S_RESP: dm_valid_o=1. On dmi_ready_i, returns to S_IDLE.
- Registers (DMI addr):
  - data0 0x04: RW. Loaded with cmd_rdata_i on a read-command ack.
  - dmcontrol 0x10:
    - haltreq[31], RW; drives halt_req_o.
    - resumereq[30], W; sets resume_req_o and clears resumeack.
    - ndmreset[1], RW; drives ndmreset_o.
    - dmactive[0], RW.
  - dmstatus 0x11, RO:
    - allresumeack[17], anyresumeack[16]
    - allrunning[11], anyrunning[10]
    - allhalted[9], anyhalted[8]
    - authenticated[7]=1
    - version[3:0]=2
  - abstractcs 0x16:
    - datacount[3:0]=1
    - cmderr[10:8], W1C
    - busy[12], RO
    - progbufsize=0
  - command 0x17, W.
  - haltsum0 0x40, RO; bit0 = halted_i.
  - Other addresses read 0; writes are ignored; response is success.
- dmactive=0:
  - All other dmcontrol bits are forced to 0.
  - The command FSM is idled.
  - cmderr is cleared.
  - data0 is retained.
- resume_req_o clears on the first cycle with halted_i=0. At the same time resumeack is set.
- Command write (cmd FSM, sub-module), evaluated in this order:
  - If busy: cmderr=1, command ignored.
  - Else if cmderr≠0: command ignored.
  - Else if cmdtype[31:24]≠0 or aarsize[22:20]≠2: cmderr=2.
  - Else if halted_i=0: cmderr=4.
  - Else if transfer[17]=0: complete immediately, no core access.
  - Else:
    - Set busy.
    - Drive cmd_req_o with cmd_we_o=write[16], cmd_addr_o=regno[15:0], cmd_wdata_o=data0.
    - On cmd_ack_i: drop cmd_req_o and clear busy. For a read, data0 ← cmd_rdata_i.
  - The DMI response to the command write is success regardless of the outcome; errors are reported only through cmderr.
- A data0 read or write while busy sets cmderr=1 (if cmderr is 0). A write is ignored; a read returns the current data0.
- Reset mid-transaction drops any pending request, response or command; no response is issued.

## Timing
- Reset values:
  - dm_valid_o=0, dm_data_o=0.
  - halt_req_o, resume_req_o, ndmreset_o, cmd_req_o and cmd_we_o are 0.
  - cmd_addr_o=0, cmd_wdata_o=0.
  - dm_ready_o=1 (state S_IDLE).
- Latency: handshake in cycle N → dm_valid_o in cycle N+2. The response is held stable until dmi_ready_i. The earliest next accept is the cycle after response consumption.
- Register write side effects (halt_req_o, ndmreset_o) are visible in cycle N+2.
- cmd_req_o rises in cycle N+2 after the command handshake. It stays high until cmd_ack_i. An ack arriving in the same cycle as the request rises is legal.
- If cmd_ack_i coincides with a DMI access to data0 in S_EXEC, the ack write wins; the DMI access sees the busy rule.

## Configuration
- DM_DATA1_EN:
  - Defined: adds data1 at 0x05 and sets datacount=2.
  - Undefined: data1 is absent (reads 0) and datacount=1.

## Structure
- Shared package dm_pkg holds:
  - DMI op/status constants
  - DM register address constants
  - cmderr codes (0 none, 1 busy, 2 not supported, 4 halt/resume)
  - State encodings
  - Packed struct typedefs for dmcontrol, abstractcs and command
- Sub-module dm_abstract_cmd: the command validation/execution FSM (C_IDLE, C_WAIT_ACK), owning busy and cmderr.

## Test plan
- Read dmstatus after reset with halted_i=0 → response {0x11, 0x00000C82, 0} in cycle N+2.
- Write dmcontrol=0x80000001 → halt_req_o=1 at N+2. Assert halted_i, then read haltsum0 → data 1.
- Halted hart, data0=0x1234, command=0x00231005 → cmd_req_o=1, cmd_we_o=1, cmd_addr_o=0x1005, cmd_wdata_o=0x1234. Ack after 5 cycles → busy clears, cmderr=0.
- Second command write while busy → cmderr=1. Write abstractcs=0x00000700 → cmderr=0.
- Command with aarsize=3 → cmderr=2. With halted_i=0 → cmderr=4. No cmd_req_o in either case.
- Hold dmi_ready_i=0 for 4 cycles → dm_data_o stable and dm_ready_o=0. Assert rst_ni=0 mid-response → dm_valid_o=0 on the next edge.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared debug-module definitions: DMI op/status codes, DM register map,
// cmderr codes, FSM encodings and register layouts.
// Optional feature macro: DM_DATA1_EN (adds data1 at 0x05, datacount=2).
package dm_pkg;

  // DMI request ops and response status
  localparam logic [1:0] DMI_OP_NOP     = 2'd0;
  localparam logic [1:0] DMI_OP_READ    = 2'd1;
  localparam logic [1:0] DMI_OP_WRITE   = 2'd2;
  localparam logic [1:0] DMI_ST_SUCCESS = 2'd0;
  localparam logic [1:0] DMI_ST_BUSY    = 2'd3;

  // DM register addresses
  localparam logic [6:0] ADDR_DATA0      = 7'h04;
  localparam logic [6:0] ADDR_DATA1      = 7'h05;
  localparam logic [6:0] ADDR_DMCONTROL  = 7'h10;
  localparam logic [6:0] ADDR_DMSTATUS   = 7'h11;
  localparam logic [6:0] ADDR_ABSTRACTCS = 7'h16;
  localparam logic [6:0] ADDR_COMMAND    = 7'h17;
  localparam logic [6:0] ADDR_HALTSUM0   = 7'h40;

  // cmderr codes
  localparam logic [2:0] CMDERR_NONE    = 3'd0;
  localparam logic [2:0] CMDERR_BUSY    = 3'd1;
  localparam logic [2:0] CMDERR_NOTSUP  = 3'd2;
  localparam logic [2:0] CMDERR_HALTRES = 3'd4;

`ifdef DM_DATA1_EN
  localparam logic [3:0] DM_DATACOUNT = 4'd2;
`else
  localparam logic [3:0] DM_DATACOUNT = 4'd1;
`endif

  localparam logic [3:0] DM_VERSION = 4'd2;

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_EXEC = 3'b010,
    S_RESP = 3'b100
  } dmi_state_e;

  typedef enum logic {
    C_IDLE     = 1'b0,
    C_WAIT_ACK = 1'b1
  } cmd_state_e;

  typedef struct packed {
    logic        haltreq;
    logic        resumereq;
    logic [27:0] rsvd;
    logic        ndmreset;
    logic        dmactive;
  } dmcontrol_t;

  typedef struct packed {
    logic [2:0]  rsvd0;
    logic [4:0]  progbufsize;
    logic [10:0] rsvd1;
    logic        busy;
    logic        rsvd2;
    logic [2:0]  cmderr;
    logic [3:0]  rsvd3;
    logic [3:0]  datacount;
  } abstractcs_t;

  typedef struct packed {
    logic [7:0]  cmdtype;
    logic        rsvd;
    logic [2:0]  aarsize;
    logic        aarpostinc;
    logic        postexec;
    logic        transfer;
    logic        write;
    logic [15:0] regno;
  } command_t;

endpackage

// File: rtl/dm_abstract_cmd.sv
// Abstract register-access command engine: validates command writes,
// drives the core access handshake and owns busy / cmderr.
module dm_abstract_cmd
  import dm_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        dmactive_i,
  input  logic        cmd_valid_i,
  input  command_t    cmd_i,
  input  logic        halted_i,
  input  logic [31:0] data0_i,
  input  logic [2:0]  cmderr_w1c_i,
  input  logic        busy_err_i,
  output logic        busy_o,
  output logic [2:0]  cmderr_o,
  output logic        cmd_req_o,
  output logic        cmd_we_o,
  output logic [15:0] cmd_addr_o,
  output logic [31:0] cmd_wdata_o,
  input  logic        cmd_ack_i,
  input  logic [31:0] cmd_rdata_i,
  output logic        data0_we_o,
  output logic [31:0] data0_wdata_o
);

  cmd_state_e  state_q, state_d;
  logic [2:0]  cmderr_q, cmderr_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic unused_cmd;
  assign unused_cmd = ^{cmd_i.rsvd, cmd_i.aarpostinc, cmd_i.postexec};

  assign cmderr_o    = cmderr_q;
  assign cmd_we_o    = we_q;
  assign cmd_addr_o  = addr_q;
  assign cmd_wdata_o = wdata_q;

  // Next state, cmderr update and core-access outputs
  always_comb begin
    state_d       = state_q;
    cmderr_d      = cmderr_q & ~cmderr_w1c_i;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    busy_o        = (state_q == C_WAIT_ACK);
    cmd_req_o     = (state_q == C_WAIT_ACK);
    data0_we_o    = 1'b0;
    data0_wdata_o = cmd_rdata_i;

    if (state_q == C_WAIT_ACK && cmd_ack_i) begin
      state_d    = C_IDLE;
      data0_we_o = ~we_q;
    end

    if (busy_err_i && cmderr_q == CMDERR_NONE) cmderr_d = CMDERR_BUSY;

    // Checks are ordered: busy, sticky error, unsupported, not halted
    if (cmd_valid_i) begin
      if (busy_o) begin
        if (cmderr_q == CMDERR_NONE) cmderr_d = CMDERR_BUSY;
      end else if (cmderr_q != CMDERR_NONE) begin
        cmderr_d = cmderr_q;
      end else if (cmd_i.cmdtype != 8'd0 || cmd_i.aarsize != 3'd2) begin
        cmderr_d = CMDERR_NOTSUP;
      end else if (!halted_i) begin
        cmderr_d = CMDERR_HALTRES;
      end else if (cmd_i.transfer) begin
        state_d = C_WAIT_ACK;
        we_d    = cmd_i.write;
        addr_d  = cmd_i.regno;
        wdata_d = data0_i;
      end
    end

    // An inactive DM abandons any access and forgets errors
    if (!dmactive_i) begin
      state_d    = C_IDLE;
      cmderr_d   = CMDERR_NONE;
      data0_we_o = 1'b0;
    end
  end

  // State and access registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= C_IDLE;
      cmderr_q <= CMDERR_NONE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cmderr_q <= cmderr_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

endmodule

// File: rtl/dm_dmi_responder.sv
// DMI responder for the debug module: accepts {addr,data,op} requests,
// decodes the DM register file, drives hart control and returns one
// response per request two cycles after the handshake.
// Optional feature macro: DM_DATA1_EN (data1 register at 0x05).
module dm_dmi_responder
  import dm_pkg::*;
#(
  parameter int DMI_ADDR_BITS = 7,
  parameter int DMI_DATA_BITS = 32,
  parameter int DMI_OP_BITS   = 2,
  parameter int DMI_REQ_BITS  = DMI_ADDR_BITS + DMI_DATA_BITS + DMI_OP_BITS
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [DMI_REQ_BITS-1:0] dmi_data_i,
  input  logic                    dmi_valid_i,
  output logic                    dm_ready_o,
  output logic [DMI_REQ_BITS-1:0] dm_data_o,
  output logic                    dm_valid_o,
  input  logic                    dmi_ready_i,
  output logic                    halt_req_o,
  output logic                    resume_req_o,
  output logic                    ndmreset_o,
  input  logic                    halted_i,
  output logic                    cmd_req_o,
  output logic                    cmd_we_o,
  output logic [15:0]             cmd_addr_o,
  output logic [31:0]             cmd_wdata_o,
  input  logic                    cmd_ack_i,
  input  logic [31:0]             cmd_rdata_i
);

  dmi_state_e               state_q, state_d;
  logic [DMI_ADDR_BITS-1:0] req_addr_q;
  logic [DMI_DATA_BITS-1:0] req_data_q;
  logic [DMI_OP_BITS-1:0]   req_op_q;
  logic [DMI_REQ_BITS-1:0]  resp_q;

  logic [31:0] data0_q;
`ifdef DM_DATA1_EN
  logic [31:0] data1_q;
`endif
  logic haltreq_q, ndmreset_q, dmactive_q, resume_req_q, resumeack_q;

  logic        exec, rd, wr;
  logic        cmd_valid, data0_acc, busy_err;
  logic [2:0]  w1c;
  logic [31:0] rdata;
  dmcontrol_t  wctl;
  abstractcs_t wacs;
  logic        busy;
  logic [2:0]  cmderr;
  logic        data0_we;
  logic [31:0] data0_wdata;

  logic unused_ok;
  assign unused_ok = ^{wctl.rsvd, wacs.rsvd0, wacs.progbufsize, wacs.rsvd1,
                       wacs.busy, wacs.rsvd2, wacs.rsvd3, wacs.datacount};

  assign dm_data_o    = resp_q;
  assign halt_req_o   = haltreq_q;
  assign ndmreset_o   = ndmreset_q;
  assign resume_req_o = resume_req_q;

  // DMI handshake FSM: idle -> exec -> respond
  always_comb begin
    state_d    = state_q;
    dm_ready_o = 1'b0;
    dm_valid_o = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        dm_ready_o = 1'b1;
        if (dmi_valid_i) state_d = S_EXEC;
      end
      S_EXEC: state_d = S_RESP;
      S_RESP: begin
        dm_valid_o = 1'b1;
        if (dmi_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Register access decode and read mux, active only in S_EXEC
  always_comb begin
    exec      = (state_q == S_EXEC);
    rd        = exec && (req_op_q == DMI_OP_READ);
    wr        = exec && (req_op_q == DMI_OP_WRITE);
    wctl      = dmcontrol_t'(req_data_q);
    wacs      = abstractcs_t'(req_data_q);
    cmd_valid = wr && (req_addr_q == ADDR_COMMAND);
    data0_acc = (rd || wr) && (req_addr_q == ADDR_DATA0);
    busy_err  = data0_acc && busy;
    w1c       = (wr && req_addr_q == ADDR_ABSTRACTCS) ? wacs.cmderr : 3'd0;
    rdata     = '0;
    case (req_addr_q)
      ADDR_DATA0:     rdata = data0_q;
`ifdef DM_DATA1_EN
      ADDR_DATA1:     rdata = data1_q;
`endif
      ADDR_DMCONTROL: rdata = {haltreq_q, 29'd0, ndmreset_q, dmactive_q};
      ADDR_DMSTATUS: begin
        rdata[17]  = resumeack_q;
        rdata[16]  = resumeack_q;
        rdata[11]  = ~halted_i;
        rdata[10]  = ~halted_i;
        rdata[9]   = halted_i;
        rdata[8]   = halted_i;
        rdata[7]   = 1'b1;
        rdata[3:0] = DM_VERSION;
      end
      ADDR_ABSTRACTCS: begin
        rdata[12]   = busy;
        rdata[10:8] = cmderr;
        rdata[3:0]  = DM_DATACOUNT;
      end
      ADDR_HALTSUM0:  rdata[0] = halted_i;
      default:        rdata = '0;
    endcase
  end

  // Request capture and response latch
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      req_addr_q <= '0;
      req_data_q <= '0;
      req_op_q   <= '0;
      resp_q     <= '0;
    end else begin
      state_q <= state_d;
      if (dm_ready_o && dmi_valid_i)
        {req_addr_q, req_data_q, req_op_q} <= dmi_data_i;
      if (exec)
        resp_q <= {req_addr_q, (rd ? rdata : 32'd0), DMI_ST_SUCCESS};
    end
  end

  // dmcontrol fields and resume handshake; clearing dmactive zeroes the rest
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      haltreq_q    <= 1'b0;
      ndmreset_q   <= 1'b0;
      dmactive_q   <= 1'b0;
      resume_req_q <= 1'b0;
      resumeack_q  <= 1'b0;
    end else begin
      if (resume_req_q && !halted_i) begin
        resume_req_q <= 1'b0;
        resumeack_q  <= 1'b1;
      end
      if (wr && req_addr_q == ADDR_DMCONTROL) begin
        dmactive_q <= wctl.dmactive;
        haltreq_q  <= wctl.dmactive & wctl.haltreq;
        ndmreset_q <= wctl.dmactive & wctl.ndmreset;
        if (!wctl.dmactive) begin
          resume_req_q <= 1'b0;
        end else if (wctl.resumereq) begin
          resume_req_q <= 1'b1;
          resumeack_q  <= 1'b0;
        end
      end
    end
  end

  // Data registers; a read-command ack beats a concurrent DMI write
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data0_q <= '0;
    end else if (data0_we) begin
      data0_q <= data0_wdata;
    end else if (wr && req_addr_q == ADDR_DATA0 && !busy) begin
      data0_q <= req_data_q;
    end
  end

`ifdef DM_DATA1_EN
  // data1 is a plain scratch register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) data1_q <= '0;
    else if (wr && req_addr_q == ADDR_DATA1) data1_q <= req_data_q;
  end
`endif

  dm_abstract_cmd u_cmd (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .dmactive_i    (dmactive_q),
    .cmd_valid_i   (cmd_valid),
    .cmd_i         (command_t'(req_data_q)),
    .halted_i      (halted_i),
    .data0_i       (data0_q),
    .cmderr_w1c_i  (w1c),
    .busy_err_i    (busy_err),
    .busy_o        (busy),
    .cmderr_o      (cmderr),
    .cmd_req_o     (cmd_req_o),
    .cmd_we_o      (cmd_we_o),
    .cmd_addr_o    (cmd_addr_o),
    .cmd_wdata_o   (cmd_wdata_o),
    .cmd_ack_i     (cmd_ack_i),
    .cmd_rdata_i   (cmd_rdata_i),
    .data0_we_o    (data0_we),
    .data0_wdata_o (data0_wdata)
  );

endmodule

// File: tb/tb_dm_dmi_responder.sv
// Directed bench for dm_dmi_responder: register map, hart control,
// abstract commands, error codes, backpressure and reset.
module tb_dm_dmi_responder;

`ifdef DM_DATA1_EN
  localparam logic [31:0] DC = 32'd2;
`else
  localparam logic [31:0] DC = 32'd1;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [40:0] dmi_data_i;
  logic        dmi_valid_i;
  logic        dm_ready_o;
  logic [40:0] dm_data_o;
  logic        dm_valid_o;
  logic        dmi_ready_i;
  logic        halt_req_o, resume_req_o, ndmreset_o;
  logic        halted_i;
  logic        cmd_req_o, cmd_we_o;
  logic [15:0] cmd_addr_o;
  logic [31:0] cmd_wdata_o;
  logic        cmd_ack_i;
  logic [31:0] cmd_rdata_i;

  int n_chk = 0;
  int n_fail = 0;

  logic [40:0] r;
  logic        ok;
  logic [2:0]  s1, s2;

  always #5 clk_i = ~clk_i;

  dm_dmi_responder dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .dmi_data_i(dmi_data_i), .dmi_valid_i(dmi_valid_i), .dm_ready_o(dm_ready_o),
    .dm_data_o(dm_data_o), .dm_valid_o(dm_valid_o), .dmi_ready_i(dmi_ready_i),
    .halt_req_o(halt_req_o), .resume_req_o(resume_req_o), .ndmreset_o(ndmreset_o),
    .halted_i(halted_i),
    .cmd_req_o(cmd_req_o), .cmd_we_o(cmd_we_o), .cmd_addr_o(cmd_addr_o),
    .cmd_wdata_o(cmd_wdata_o), .cmd_ack_i(cmd_ack_i), .cmd_rdata_i(cmd_rdata_i)
  );

  // One DMI transaction. ok=0 if the accept times out or the response is
  // not exactly two cycles after the handshake. s1/s2 snapshot
  // {halt_req, ndmreset, cmd_req} in cycles N+1 and N+2.
  task automatic xfer(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op,
                      output logic [40:0] resp, output logic lat_ok,
                      output logic [2:0] snap1, output logic [2:0] snap2);
    int t;
    lat_ok = 1'b1;
    @(negedge clk_i);
    dmi_data_i  = {a, d, op};
    dmi_valid_i = 1'b1;
    t = 0;
    while (!dm_ready_o && t < 16) begin @(negedge clk_i); t++; end
    if (!dm_ready_o) lat_ok = 1'b0;
    @(posedge clk_i); #1;
    dmi_valid_i = 1'b0;
    dmi_data_i  = '0;
    @(negedge clk_i);
    snap1 = {halt_req_o, ndmreset_o, cmd_req_o};
    if (dm_valid_o) lat_ok = 1'b0;
    @(negedge clk_i);
    snap2 = {halt_req_o, ndmreset_o, cmd_req_o};
    if (!dm_valid_o) lat_ok = 1'b0;
    resp = dm_data_o;
    dmi_ready_i = 1'b1;
    @(posedge clk_i); #1;
    dmi_ready_i = 1'b0;
  endtask

  task automatic ack(input logic [31:0] rd);
    @(negedge clk_i);
    cmd_ack_i   = 1'b1;
    cmd_rdata_i = rd;
    @(negedge clk_i);
    cmd_ack_i   = 1'b0;
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    n_chk++;
    if ({dm_valid_o, dm_data_o} !== 42'd0) begin
      n_fail++; $display("FAIL reset_resp: got valid=%0b data=%h, want 0/0", dm_valid_o, dm_data_o);
    end
    n_chk++;
    if ({halt_req_o, resume_req_o, ndmreset_o, cmd_req_o, cmd_we_o} !== 5'd0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b, want 00000",
                         {halt_req_o, resume_req_o, ndmreset_o, cmd_req_o, cmd_we_o});
    end
    n_chk++;
    if ({cmd_addr_o, cmd_wdata_o} !== 48'd0 || dm_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_cmd: got addr=%h wdata=%h ready=%0b, want 0/0/1",
                         cmd_addr_o, cmd_wdata_o, dm_ready_o);
    end
    rst_ni = 1'b1;
  endtask

  task automatic test_dmstatus;
    halted_i = 1'b0;
    xfer(7'h11, 32'h0, 2'd1, r, ok, s1, s2);
    n_chk++;
    if (r !== {7'h11, 32'h00000C82, 2'd0} || !ok) begin
      n_fail++; $display("FAIL dmstatus_reset: got %h ok=%0b, want %h", r, ok, {7'h11, 32'h00000C82, 2'd0});
    end
  endtask

  task automatic test_halt;
    xfer(7'h10, 32'h80000001, 2'd2, r, ok, s1, s2);
    n_chk++;
    if (s1[2] !== 1'b0 || s2[2] !== 1'b1 || !ok) begin
      n_fail++; $display("FAIL halt_timing: got n1=%0b n2=%0b ok=%0b, want 0/1/1", s1[2], s2[2], ok);
    end
    n_chk++;
    if (r !== {7'h10, 32'h0, 2'd0}) begin
      n_fail++; $display("FAIL write_resp: got %h, want %h", r, {7'h10, 32'h0, 2'd0});
    end
    halted_i = 1'b1;
    xfer(7'h40, 32'h0, 2'd1, r, ok, s1, s2);
    n_chk++;
    if (r !== {7'h40, 32'h1, 2'd0}) begin
      n_fail++; $display("FAIL haltsum0: got %h, want %h", r, {7'h40, 32'h1, 2'd0});
    end
    xfer(7'h10, 32'h0, 2'd1, r, ok, s1, s2);
    n_chk++;
    if (r[33:2] !== 32'h80000001) begin
      n_fail++; $display("FAIL dmcontrol_rd: got %h, want 80000001", r[33:2]);
    end
    xfer(7'h11, 32'h0, 2'd1, r, ok, s1, s2);
    n_chk++;
    if (r[33:2] !== 32'h00000382) begin
      n_fail++; $display("FAIL dmstatus_halted: got %h, want 00000382", r[33:2]);
    end
  endtask

  task automatic test_command;
    xfer(7'h04, 32'h1234, 2'd2, r, ok, s1, s2);
    xfer(7'h17, 32'h00231005, 2'd2, r, ok, s1, s2);
    n_chk++;
    if (s1[0] !== 1'b0 || s2[0] !== 1'b1 || r !== {7'h17, 32'h0, 2'd0}) begin
      n_fail++; $display("FAIL cmd_req_timing: got n1=%0b n2=%0b resp=%h, want 0/1/%h",
                         s1[0], s2[0], r, {7'h17, 32'h0, 2'd0});
    end
    n_chk++;
    if ({cmd_we_o, cmd_addr_o, cmd_wdata_o} !== {1'b1, 16'h1005, 32'h1234}) begin
      n_fail++; $display("FAIL cmd_fields: got we=%0b addr=%h wdata=%h, want 1/1005/00001234",
                         cmd_we_o, cmd_addr_o, cmd_wdata_o);
    end
    repeat (5) @(negedge clk_i);
    n_chk++;
    if (cmd_req_o !== 1'b1) begin
      n_fail++; $display("FAIL cmd_req_hold: got %0b, want 1", cmd_req_o);
    end
    ack(32'h0);
    n_chk++;
    if (cmd_req_o !== 1'b0) begin
      n_fail++; $display("FAIL cmd_req_drop: got %0b, want 0", cmd_req_o);
    end
    xfer(7'h16, 32'h0, 2'd1, r, ok, s1, s2);
    n_chk++;
    if (r[33:2] !== DC) begin
      n_fail++; $display("FAIL acs_after_ack: got %h, want %h", r[33:2], DC);
    end
    // Second command while the first is still in flight
    xfer(7'h17, 32'h00231005, 2'd2, r, ok, s1, s2);
    xfer(7'h17, 32'h00231006, 2'd2, r, ok, s1, s2);
    xfer(7'h16, 32'h0, 2'd1, r, ok, s1, s2);
    n_chk++;
    if (r[33:2] !== (32'h1100 | DC) || cmd_addr_o !== 16'h1005) begin
      n_fail++; $display("FAIL cmd_busy_err: got acs=%h addr=%h, want %h/1005", r[33:2], cmd_addr_o, 32'h1100 | DC);
    end
    ack(32'h0);
    xfer(7'h16, 32'h00000700, 2'd2, r, ok, s1, s2);
    xfer(7'h16, 32'h0, 2'd1, r, ok, s1, s2);
    n_chk++;
    if (r[33:2] !== DC) begin
      n_fail++; $display("FAIL cmderr_w1c: got %h, want %h", r[33:2], DC);
    end
    // Read command; data0 access while busy reports busy but returns data0
    xfer(7'h17, 32'h00221007, 2'd2, r, ok, s1, s2);
    n_chk++;
    if ({cmd_req_o, cmd_we_o, cmd_addr_o} !== {2'b10, 16'h1007}) begin
      n_fail++; $display("FAIL rd_cmd_fields: got req=%0b we=%0b addr=%h, want 1/0/1007",
                         cmd_req_o, cmd_we_o, cmd_addr_o);
    end
    xfer(7'h04, 32'h0, 2'd1, r, ok, s1, s2);
    n_chk++;
    if (r[33:2] !== 32'h1234) begin
      n_fail++; $display("FAIL data0_busy_rd: got %h, want 00001234", r[33:2]);
    end
    xfer(7'h16, 32'h0, 2'd1, r, ok, s1, s2);
    n_chk++;
    if (r[33:2] !== (32'h1100 | DC)) begin
      n_fail++; $display("FAIL data0_busy_err: got %h, want %h", r[33:2], 32'h1100 | DC);
    end
    ack(32'hCAFEF00D);
    xfer(7'h04, 32'h0, 2'd1, r, ok, s1, s2);
    n_chk++;
    if (r !== {7'h04, 32'hCAFEF00D, 2'd0}) begin
      n_fail++; $display("FAIL data0_from_ack: got %h, want %h", r, {7'h04, 32'hCAFEF00D, 2'd0});
    end
    xfer(7'h16, 32'h00000700, 2'd2, r, ok, s1, s2);
  endtask

  task automatic test_cmd_errors;
    xfer(7'h17, 32'h00331005, 2'd2, r, ok, s1, s2);
    xfer(7'h16, 32'h0, 2'd1, r, ok, s1, s2);
    n_chk++;
    if (r[33:2] !== (32'h0200 | DC) || s2[0] !== 1'b0 || cmd_req_o !== 1'b0) begin
      n_fail++; $display("FAIL cmderr_notsup: got acs=%h req=%0b, want %h/0", r[33:2], cmd_req_o, 32'h0200 | DC);
    end
    xfer(7'h16, 32'h00000700, 2'd2, r, ok, s1, s2);
    halted_i = 1'b0;
    xfer(7'h17, 32'h00231005, 2'd2, r, ok, s1, s2);
    n_chk++;
    if (s2[0] !== 1'b0 || cmd_req_o !== 1'b0) begin
      n_fail++; $display("FAIL notrun_no_req: got %0b/%0b, want 0/0", s2[0], cmd_req_o);
    end
    xfer(7'h16, 32'h0, 2'd1, r, ok, s1, s2);
    n_chk++;
    if (r[33:2] !== (32'h0400 | DC)) begin
      n_fail++; $display("FAIL cmderr_halt: got %h, want %h", r[33:2], 32'h0400 | DC);
    end
    xfer(7'h16, 32'h00000700, 2'd2, r, ok, s1, s2);
    halted_i = 1'b1;
    xfer(7'h17, 32'h00201005, 2'd2, r, ok, s1, s2);
    xfer(7'h16, 32'h0, 2'd1, r, ok, s1, s2);
    n_chk++;
    if (r[33:2] !== DC || cmd_req_o !== 1'b0) begin
      n_fail++; $display("FAIL no_transfer: got acs=%h req=%0b, want %h/0", r[33:2], cmd_req_o, DC);
    end
  endtask

  task automatic test_resume;
    xfer(7'h10, 32'h40000001, 2'd2, r, ok, s1, s2);
    n_chk++;
    if (resume_req_o !== 1'b1 || halt_req_o !== 1'b0) begin
      n_fail++; $display("FAIL resume_set: got resume=%0b halt=%0b, want 1/0", resume_req_o, halt_req_o);
    end
    @(negedge clk_i);
    halted_i = 1'b0;
    @(negedge clk_i);
    n_chk++;
    if (resume_req_o !== 1'b0) begin
      n_fail++; $display("FAIL resume_clear: got %0b, want 0", resume_req_o);
    end
    xfer(7'h11, 32'h0, 2'd1, r, ok, s1, s2);
    n_chk++;
    if (r[33:2] !== 32'h00030C82) begin
      n_fail++; $display("FAIL resumeack: got %h, want 00030C82", r[33:2]);
    end
    halted_i = 1'b1;
  endtask

  task automatic test_dmactive;
    xfer(7'h10, 32'h80000003, 2'd2, r, ok, s1, s2);
    n_chk++;
    if (s2[2:1] !== 2'b11) begin
      n_fail++; $display("FAIL ndmreset_set: got %b, want 11", s2[2:1]);
    end
    xfer(7'h17, 32'h00331005, 2'd2, r, ok, s1, s2);
    xfer(7'h10, 32'h80000002, 2'd2, r, ok, s1, s2);
    n_chk++;
    if ({halt_req_o, ndmreset_o, resume_req_o} !== 3'b000) begin
      n_fail++; $display("FAIL dmactive_force: got %b, want 000", {halt_req_o, ndmreset_o, resume_req_o});
    end
    xfer(7'h10, 32'h0, 2'd1, r, ok, s1, s2);
    n_chk++;
    if (r[33:2] !== 32'h0) begin
      n_fail++; $display("FAIL dmcontrol_inactive: got %h, want 00000000", r[33:2]);
    end
    xfer(7'h10, 32'h00000001, 2'd2, r, ok, s1, s2);
    xfer(7'h16, 32'h0, 2'd1, r, ok, s1, s2);
    n_chk++;
    if (r[33:2] !== DC) begin
      n_fail++; $display("FAIL cmderr_cleared: got %h, want %h", r[33:2], DC);
    end
    xfer(7'h04, 32'h0, 2'd1, r, ok, s1, s2);
    n_chk++;
    if (r[33:2] !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL data0_retained: got %h, want CAFEF00D", r[33:2]);
    end
  endtask

  task automatic test_unmapped;
    logic [31:0] d1;
    xfer(7'h20, 32'hDEADBEEF, 2'd2, r, ok, s1, s2);
    xfer(7'h20, 32'h0, 2'd1, r, ok, s1, s2);
    n_chk++;
    if (r !== {7'h20, 32'h0, 2'd0}) begin
      n_fail++; $display("FAIL unmapped_rd: got %h, want %h", r, {7'h20, 32'h0, 2'd0});
    end
    xfer(7'h04, 32'h5555AAAA, 2'd3, r, ok, s1, s2);
    xfer(7'h04, 32'h0, 2'd0, r, ok, s1, s2);
    n_chk++;
    if (r !== {7'h04, 32'h0, 2'd0}) begin
      n_fail++; $display("FAIL nop_resp: got %h, want %h", r, {7'h04, 32'h0, 2'd0});
    end
    xfer(7'h04, 32'h0, 2'd1, r, ok, s1, s2);
    n_chk++;
    if (r[33:2] !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL reserved_op: got %h, want CAFEF00D", r[33:2]);
    end
    xfer(7'h05, 32'h0BADF00D, 2'd2, r, ok, s1, s2);
    xfer(7'h05, 32'h0, 2'd1, r, ok, s1, s2);
`ifdef DM_DATA1_EN
    d1 = 32'h0BADF00D;
`else
    d1 = 32'h0;
`endif
    n_chk++;
    if (r[33:2] !== d1) begin
      n_fail++; $display("FAIL data1: got %h, want %h", r[33:2], d1);
    end
  endtask

  task automatic test_backpressure_reset;
    logic [40:0] hold;
    @(negedge clk_i);
    dmi_data_i  = {7'h40, 32'h0, 2'd1};
    dmi_valid_i = 1'b1;
    @(posedge clk_i); #1;
    dmi_valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    hold = dm_data_o;
    n_chk++;
    if (hold !== {7'h40, 32'h1, 2'd0} || dm_valid_o !== 1'b1) begin
      n_fail++; $display("FAIL bp_resp: got %h valid=%0b, want %h/1", hold, dm_valid_o, {7'h40, 32'h1, 2'd0});
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      n_chk++;
      if (dm_data_o !== hold || dm_valid_o !== 1'b1 || dm_ready_o !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold%0d: got %h v=%0b r=%0b, want %h/1/0",
                           i, dm_data_o, dm_valid_o, dm_ready_o, hold);
      end
    end
    rst_ni = 1'b0;
    @(negedge clk_i);
    n_chk++;
    if (dm_valid_o !== 1'b0 || dm_data_o !== 41'd0 || dm_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_resp: got v=%0b d=%h r=%0b, want 0/0/1", dm_valid_o, dm_data_o, dm_ready_o);
    end
    rst_ni = 1'b1;
    xfer(7'h11, 32'h0, 2'd1, r, ok, s1, s2);
    n_chk++;
    if (r !== {7'h11, 32'h00000382, 2'd0} || !ok) begin
      n_fail++; $display("FAIL post_reset_rd: got %h ok=%0b, want %h", r, ok, {7'h11, 32'h00000382, 2'd0});
    end
  endtask

  initial begin
    rst_ni      = 1'b0;
    dmi_data_i  = '0;
    dmi_valid_i = 1'b0;
    dmi_ready_i = 1'b0;
    halted_i    = 1'b0;
    cmd_ack_i   = 1'b0;
    cmd_rdata_i = '0;
    test_reset();
    test_dmstatus();
    test_halt();
    test_command();
    test_cmd_errors();
    test_resume();
    test_dmactive();
    test_unmapped();
    test_backpressure_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
